// File: rtl/div3_pkg.sv
// div3_pkg: shared types and constants for the divide-by-three stream controller
package div3_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef logic [1:0] rem_t;
  localparam int HIT_COUNT_W = 16;
endpackage

// File: rtl/div3_nibble_stage.sv
// div3_nibble_stage: folds one nibble into a running mod-3 remainder (16 mod 3 == 1)
module div3_nibble_stage
  import div3_pkg::*;
(
  input  rem_t       rem_in,
  input  logic [3:0] nib,
  output rem_t       rem_out
);
  logic [4:0] sum;
  always_comb begin
    sum = {3'b000, rem_in} + {1'b0, nib};
    rem_out = 2'(sum % 5'd3);
  end
endmodule

// File: rtl/div3_stream_ctrl.sv
// div3_stream_ctrl: streams an operand MSB nibble first to decide divisibility by three
// Optional saturating hit_count output enabled by DIV3_HIT_COUNT_EN.
module div3_stream_ctrl
  import div3_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] operand,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             divisible,
  output logic [1:0]       remainder
`ifdef DIV3_HIT_COUNT_EN
  ,
  output logic [HIT_COUNT_W-1:0] hit_count
`endif
);
  localparam int NIB = WIDTH / 4;
  localparam int CW = (NIB > 1) ? $clog2(NIB) : 1;
  state_t state, state_nxt;
  logic [WIDTH-1:0] sh;
  logic [CW-1:0] cnt;
  rem_t rem, rem_nxt;
  logic accept, last;
  div3_nibble_stage u_stage (
    .rem_in (rem),
    .nib    (sh[WIDTH-1 -: 4]),
    .rem_out(rem_nxt)
  );
  always_comb begin
    accept = ready & start;
    last = (state == RUN) && (cnt == CW'(NIB - 1));
    state_nxt = (state == RUN) ? (last ? DONE : RUN) : (accept ? RUN : IDLE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sh <= '0;
      cnt <= '0;
      rem <= '0;
      ready <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
      divisible <= 1'b0;
      remainder <= '0;
    end else begin
      state <= state_nxt;
      ready <= state_nxt != RUN;
      busy <= state_nxt == RUN;
      done <= state_nxt == DONE;
      if (accept) begin
        sh <= operand;
        rem <= '0;
        cnt <= '0;
      end else if (state == RUN) begin
        sh <= sh << 4;
        rem <= rem_nxt;
        cnt <= cnt + CW'(1);
      end
      if (last) begin
        remainder <= rem_nxt;
        divisible <= rem_nxt == 2'd0;
      end
    end
  end
`ifdef DIV3_HIT_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) hit_count <= '0;
    else if (done && divisible && hit_count != '1) hit_count <= hit_count + 1'b1;
  end
`endif
endmodule
